// File: rtl/array_mul_8x8.sv
// Exact unsigned 8x8 ripple-array multiplier with registered operands and product.
// Two-cycle latency, accepts a new operand pair every cycle, never stalls.
module array_mul_8x8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic        in_valid,
  output logic [15:0] R,
  output logic        out_valid
);

  logic [7:0]  r_a_q;
  logic [7:0]  r_b_q;
  logic        r_v_q;
  logic [15:0] r_r;
  logic        r_out_valid;
  logic [15:0] w_prod;

  // Row i adds partial product row pp[i] to the previous row's sums shifted right by one,
  // with the previous row's carry-out entering the top bit.
  // Bit 0 of each row sees no incoming carry, so it behaves as a half adder.
  // Each row retires one low product bit; the last row supplies bits 8..15.
  function automatic logic [15:0] f_array_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0]  acc;
    logic [7:0]  addend;
    logic [7:0]  prev;
    logic [15:0] prod;
    logic        cy;
    logic        c;
    logic        x;
    logic        y;
    prod   = 16'd0;
    acc    = a & {8{b[0]}};
    prod[0] = acc[0];
    cy     = 1'b0;
    for (int i = 1; i < 8; i++) begin
      addend = a & {8{b[i]}};
      prev   = {cy, acc[7:1]};
      c      = 1'b0;
      for (int j = 0; j < 8; j++) begin
        x      = addend[j];
        y      = prev[j];
        acc[j] = x ^ y ^ c;
        c      = (x & y) | (x & c) | (y & c);
      end
      cy      = c;
      prod[i] = acc[0];
    end
    prod[15:8] = {cy, acc[7:1]};
    return prod;
  endfunction

  // Combinational array between the operand and product registers.
  always_comb begin
    w_prod = f_array_mul(r_a_q, r_b_q);
  end

  // Operand stage: loads every edge; the valid flag travels alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_q <= 8'd0;
      r_b_q <= 8'd0;
      r_v_q <= 1'b0;
    end else begin
      r_a_q <= A;
      r_b_q <= B;
      r_v_q <= in_valid;
    end
  end

  // Product stage: R updates every edge, out_valid alone qualifies it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_r         <= 16'd0;
      r_out_valid <= 1'b0;
    end else begin
      r_r         <= w_prod;
      r_out_valid <= r_v_q;
    end
  end

  assign R         = r_r;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_array_mul_8x8.sv
// Scoreboard bench for array_mul_8x8: stimulus pushes A*B, a negedge monitor pops and compares.
module tb_array_mul_8x8;

  logic        clk;
  logic        rst_n;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        in_valid;
  logic [15:0] R;
  logic        out_valid;

  logic [15:0] sb_q[$];
  int unsigned n_checks;
  int unsigned n_fail;
  logic        exp_v1;
  logic        exp_v2;

  array_mul_8x8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .in_valid  (in_valid),
    .R         (R),
    .out_valid (out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference: out_valid is in_valid seen two edges earlier, cleared by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_v1 <= 1'b0;
      exp_v2 <= 1'b0;
    end else begin
      exp_v1 <= in_valid;
      exp_v2 <= exp_v1;
    end
  end

  // Monitor: compare valid timing every cycle, pop a product whenever out_valid is high.
  always @(negedge clk) begin
    if (rst_n) begin
      check("out_valid_timing", {31'd0, out_valid}, {31'd0, exp_v2});
      if (out_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          check("product", {16'd0, R}, {16'd0, sb_q.pop_front()});
        end
      end
    end
  end

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic v);
    @(posedge clk);
    #1;
    A        = a;
    B        = b;
    in_valid = v;
    if (v && rst_n) sb_q.push_back(16'(a) * 16'(b));
  endtask

  initial begin
    logic [7:0] ca[5];
    logic [7:0] cb[5];
    n_checks = 0;
    n_fail   = 0;
    ca = '{8'd0, 8'd255, 8'd1, 8'd128, 8'd170};
    cb = '{8'd0, 8'd255, 8'd173, 8'd2, 8'd85};

    // Reset held with valid operands present.
    rst_n    = 1'b0;
    A        = 8'd200;
    B        = 8'd100;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_R", {16'd0, R}, 32'd0);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb_q.push_back(16'd20000);
    drive(8'd0, 8'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("release_R", {16'd0, R}, 32'd20000);
    check("release_out_valid", {31'd0, out_valid}, 32'd1);

    // Corner operand pairs.
    for (int i = 0; i < 5; i++) begin
      drive(ca[i], cb[i], 1'b1);
      drive(8'd0, 8'd0, 1'b0);
    end
    repeat (2) drive(8'd0, 8'd0, 1'b0);

    // Streaming back-to-back.
    drive(8'd3, 8'd5, 1'b1);
    drive(8'd7, 8'd9, 1'b1);
    drive(8'd15, 8'd17, 1'b1);
    repeat (3) drive(8'd0, 8'd0, 1'b0);

    // Valid gap: the middle pair still flows through the array.
    drive(8'd11, 8'd13, 1'b1);
    drive(8'd6, 8'd7, 1'b0);
    drive(8'd19, 8'd23, 1'b1);
    drive(8'd0, 8'd0, 1'b0);
    check("gap_middle_R", {16'd0, R}, 32'd42);
    repeat (3) drive(8'd0, 8'd0, 1'b0);

    // Async reset while products are in flight.
    drive(8'd99, 8'd77, 1'b1);
    drive(8'd250, 8'd3, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_R", {16'd0, R}, 32'd0);
    check("async_reset_out_valid", {31'd0, out_valid}, 32'd0);
    sb_q.delete();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) drive(8'd0, 8'd0, 1'b0);

    // Randomized operands and valid pattern.
    for (int i = 0; i < 500; i++) begin
      drive(8'($urandom_range(255)), 8'($urandom_range(255)), 1'($urandom_range(1)));
    end
    repeat (3) drive(8'd0, 8'd0, 1'b0);

    // Exhaustive sweep, one pair per cycle.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        drive(8'(a), 8'(b), 1'b1);
      end
    end
    repeat (4) drive(8'd0, 8'd0, 1'b0);
    @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/array_mul_8x8.md
Name: array_mul_8x8

Overview:
- Exact unsigned 8x8 array multiplier producing a 16-bit product. It is built as a classic carry-save/ripple array of AND partial products and full/half adders, with no approximation and no carry disregard.
- Registered on both sides: inputs are captured, the product is computed combinationally through the array, and the product is registered out.
- It is the exact baseline against which the approximate multiplier variants are compared.

Parameters:
- None. Widths are fixed: 8-bit operands, 16-bit result.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- A  input  8  unsigned multiplicand
- B  input  8  unsigned multiplier
- in_valid  input  1  A/B are valid this cycle
- R  output  16  unsigned product A*B
- out_valid  output  1  R holds the product of an accepted operand pair

Behaviour:
- Reset (rst_n=0, asynchronous assert, synchronous-to-clk deassert handled by the system):
  - Input registers A_q, B_q, R, in_valid stage flag and out_valid all clear to 0 immediately.
  - Reset mid-operation discards in-flight products; no stale value appears after release.
- Pipeline, 2-cycle latency, fully pipelined (one new pair accepted every cycle, no stall, no backpressure):
  - Edge k: A_q<=A, B_q<=B, v_q<=in_valid.
  - Edge k+1: R<=array(A_q,B_q), out_valid<=v_q.
- Operand registers load on every edge regardless of in_valid. R also updates every edge. out_valid alone qualifies the result.
- Array structure:
  - Partial products pp[i][j] = A[j] & B[i], for i,j in 0..7.
  - Row 0 passes pp[0] through; R bit 0 = pp[0][0].
  - Each row i=1..7 adds pp[i] to the shifted sum of the previous row using full adders, with half adders where only two bits exist.
  - Each row emits one low product bit.
  - The final row's sums and carry-out form bits 8..15.
- Arithmetic:
  - R = A*B exactly, unsigned, for all 65536 operand pairs.
  - Max is 255*255 = 65025 (0xFE01). No overflow is possible in 16 bits.
  - No carry is truncated or ignored anywhere in the array.
- Boundary conditions:
  - Either operand 0 gives R=0.
  - Operand 1 gives R = the other operand.
  - Powers of two give shifted values.
  - Back-to-back changing operands each produce their own product exactly 2 cycles later.
- No X propagation after reset. All outputs are driven from flops.

Test Plan:
- Reset: hold rst_n=0 with A=200, B=100, in_valid=1 -> R=0, out_valid=0. Release; 2 edges later R=20000, out_valid=1.
- Corners: (0,0)->0; (255,255)->65025; (1,173)->173; (128,2)->256; (170,85)->14450. Each is checked 2 cycles after the pair is applied with in_valid=1.
- Streaming: apply (3,5), (7,9), (15,17) on consecutive cycles -> R = 15, 63, 255 on consecutive cycles starting 2 cycles after the first. out_valid stays high for those 3 cycles.
- Valid gaps: in_valid pattern 1,0,1 -> out_valid pattern 1,0,1 delayed by 2 cycles. R still shows the array result of the middle operands.
- Async reset mid-stream: assert rst_n=0 between clock edges while products are in flight -> R and out_valid go 0 immediately, before the next edge.
- Exhaustive: sweep A=0..255 nested with B=0..255, one pair per cycle -> every R equals A*B, compared 2 cycles after application; 65536 checks, zero mismatches.
